// File: rtl/param_stack.sv
// param_stack: parameterised LIFO stack with top/next views and sticky error flags
module param_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             swap_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             clr_err_i,
    output logic [WIDTH-1:0] tos_o,
    output logic [WIDTH-1:0] nos_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             overflow_o,
    output logic             underflow_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d, cm1, cm2;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             ovf_set, unf_set, wr_en, sw_en, few;
    logic [AW-1:0]    wr_idx, top_idx, nxt_idx;

    assign cm1         = count_q - CW'(1);
    assign cm2         = count_q - CW'(2);
    assign top_idx     = cm1[AW-1:0];
    assign nxt_idx     = cm2[AW-1:0];
    assign empty_o     = count_q == '0;
    assign full_o      = count_q == CW'(DEPTH);
    assign few         = count_q < CW'(2);
    assign count_o     = count_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
    assign tos_o       = empty_o ? '0 : mem_q[top_idx];
    assign nos_o       = few ? '0 : mem_q[nxt_idx];

    // decode push/pop/swap into a write, an exchange, a count change and error events
    always_comb begin
        count_d = count_q;
        wr_en   = 1'b0;
        sw_en   = 1'b0;
        wr_idx  = count_q[AW-1:0];
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (push_i && pop_i) begin
            wr_en   = 1'b1;
            wr_idx  = empty_o ? '0 : top_idx;
            count_d = empty_o ? CW'(1) : count_q;
        end else if (push_i) begin
            ovf_set = full_o;
            wr_en   = !full_o;
            count_d = full_o ? count_q : count_q + CW'(1);
        end else if (pop_i) begin
            unf_set = empty_o;
            count_d = empty_o ? count_q : cm1;
        end else if (swap_i) begin
            unf_set = few;
            sw_en   = !few;
        end
        ovf_d = (ovf_q && !clr_err_i) || ovf_set;
        unf_d = (unf_q && !clr_err_i) || unf_set;
    end

    // count and sticky flags, cleared by reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // entry storage, never cleared; writes suppressed while in reset
    always_ff @(posedge clk_i) begin
        if (rst_ni && wr_en) begin
            mem_q[wr_idx] <= din_i;
        end else if (rst_ni && sw_en) begin
            mem_q[top_idx] <= mem_q[nxt_idx];
            mem_q[nxt_idx] <= mem_q[top_idx];
        end
    end
endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: scoreboard bench for param_stack against a behavioural LIFO model
module tb_param_stack;
    localparam int D = 16;

    typedef struct packed {
        logic [4:0] cnt;
        logic [7:0] tos;
        logic [7:0] nos;
        logic       emp;
        logic       ful;
        logic       ovf;
        logic       unf;
    } snap_t;

    typedef struct packed {
        logic       rn;
        logic       pu;
        logic       po;
        logic       sw;
        logic       clr;
        logic [7:0] d;
    } op_t;

    logic       clk = 0;
    logic       rst_n = 0, push = 0, pop = 0, swap = 0, clr_err = 0;
    logic [7:0] din = 0;
    logic [7:0] tos, nos;
    logic [4:0] count;
    logic       empty, full, overflow, underflow;

    int    checks = 0, passed = 0;
    snap_t sb[$];
    logic [7:0] m_mem [D];
    int    m_cnt = 0;
    logic  m_ovf = 0, m_unf = 0;

    param_stack #(.WIDTH(8), .DEPTH(D)) dut (
        .clk_i(clk), .rst_ni(rst_n), .push_i(push), .pop_i(pop), .swap_i(swap),
        .din_i(din), .clr_err_i(clr_err), .tos_o(tos), .nos_o(nos), .count_o(count),
        .empty_o(empty), .full_o(full), .overflow_o(overflow), .underflow_o(underflow)
    );

    always #5 clk = ~clk;

    function automatic op_t mk(logic rn, logic pu, logic po, logic sw, logic clr, logic [7:0] d);
        return '{rn: rn, pu: pu, po: po, sw: sw, clr: clr, d: d};
    endfunction

    function automatic snap_t observed();
        return '{cnt: count, tos: tos, nos: nos, emp: empty, ful: full, ovf: overflow, unf: underflow};
    endfunction

    // drive one operation, advance the model, queue its expected view, then cross one edge
    task automatic step(input op_t o);
        logic ov, un;
        logic [7:0] t;
        snap_t e;
        {rst_n, push, pop, swap, clr_err, din} = {o.rn, o.pu, o.po, o.sw, o.clr, o.d};
        ov = 0;
        un = 0;
        if (!o.rn) begin
            m_cnt = 0;
            m_ovf = 0;
            m_unf = 0;
        end else begin
            if (o.pu && o.po) begin
                if (m_cnt == 0) begin m_mem[0] = o.d; m_cnt = 1; end
                else m_mem[m_cnt-1] = o.d;
            end else if (o.pu) begin
                if (m_cnt == D) ov = 1;
                else begin m_mem[m_cnt] = o.d; m_cnt++; end
            end else if (o.po) begin
                if (m_cnt == 0) un = 1;
                else m_cnt--;
            end else if (o.sw) begin
                if (m_cnt < 2) un = 1;
                else begin
                    t = m_mem[m_cnt-1];
                    m_mem[m_cnt-1] = m_mem[m_cnt-2];
                    m_mem[m_cnt-2] = t;
                end
            end
            m_ovf = (m_ovf && !o.clr) || ov;
            m_unf = (m_unf && !o.clr) || un;
        end
        e.cnt = 5'(m_cnt);
        e.tos = m_cnt >= 1 ? m_mem[m_cnt-1] : 8'h00;
        e.nos = m_cnt >= 2 ? m_mem[m_cnt-2] : 8'h00;
        e.emp = m_cnt == 0;
        e.ful = m_cnt == D;
        e.ovf = m_ovf;
        e.unf = m_unf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        {rst_n, push, pop, swap, clr_err, din} = {1'b1, 5'b0, 8'h00};
    endtask

    task automatic test_reset();
        op_t ops[$];
        snap_t e, a;
        ops = '{mk(0,0,0,0,0,0), mk(1,1,0,0,0,8'h44), mk(0,1,0,0,0,8'h55), mk(0,0,1,0,1,0),
                mk(1,0,0,0,0,0)};
        foreach (ops[i]) begin
            step(ops[i]);
            e = sb.pop_front();
            a = observed();
            checks++;
            if (a !== e) $display("FAIL reset[%0d] got %h expected %h", i, a, e);
            else passed++;
        end
        checks++;
        if (tos !== 8'h00 || count !== 5'd0) $display("FAIL reset_const tos=%h count=%0d expected 00/0", tos, count);
        else passed++;
    endtask

    task automatic test_push3();
        op_t ops[$];
        snap_t e, a;
        ops = '{mk(0,0,0,0,0,0), mk(1,1,0,0,0,8'h11), mk(1,1,0,0,0,8'h22), mk(1,1,0,0,0,8'h33)};
        foreach (ops[i]) begin
            step(ops[i]);
            e = sb.pop_front();
            a = observed();
            checks++;
            if (a !== e) $display("FAIL push3[%0d] got %h expected %h", i, a, e);
            else passed++;
        end
        checks++;
        if (count !== 5'd3 || tos !== 8'h33 || nos !== 8'h22 || empty !== 1'b0)
            $display("FAIL push3_const count=%0d tos=%h nos=%h empty=%b expected 3/33/22/0", count, tos, nos, empty);
        else passed++;
    endtask

    task automatic test_full();
        op_t ops[$];
        snap_t e, a;
        ops = '{mk(0,0,0,0,0,0)};
        for (int v = 1; v <= D; v++) ops.push_back(mk(1,1,0,0,0,8'(v)));
        ops.push_back(mk(1,1,0,0,0,8'hFF));
        ops.push_back(mk(1,0,0,0,1,0));
        ops.push_back(mk(1,1,1,0,0,8'h7E));
        ops.push_back(mk(1,0,0,1,0,0));
        foreach (ops[i]) begin
            step(ops[i]);
            e = sb.pop_front();
            a = observed();
            checks++;
            if (a !== e) $display("FAIL full[%0d] got %h expected %h", i, a, e);
            else passed++;
        end
        checks++;
        if (count !== 5'd16 || tos !== 8'h0F || nos !== 8'h7E || overflow !== 1'b0)
            $display("FAIL full_const count=%0d tos=%h nos=%h ovf=%b expected 16/0f/7e/0", count, tos, nos, overflow);
        else passed++;
    endtask

    task automatic test_underflow();
        op_t ops[$];
        snap_t e, a;
        ops = '{mk(0,0,0,0,0,0), mk(1,0,1,0,0,0), mk(1,1,0,0,0,8'h01), mk(1,0,0,1,0,0),
                mk(1,0,0,1,1,0), mk(1,0,0,0,1,0), mk(1,1,0,1,0,8'h02), mk(1,0,1,1,0,0)};
        foreach (ops[i]) begin
            step(ops[i]);
            e = sb.pop_front();
            a = observed();
            checks++;
            if (a !== e) $display("FAIL underflow[%0d] got %h expected %h", i, a, e);
            else passed++;
        end
    endtask

    task automatic test_swap();
        op_t ops[$];
        snap_t e, a;
        ops = '{mk(0,0,0,0,0,0), mk(1,1,0,0,0,8'h11), mk(1,1,0,0,0,8'h22), mk(1,0,0,1,0,0),
                mk(1,1,1,0,0,8'h55), mk(1,1,1,1,0,8'h66), mk(1,0,0,1,0,0)};
        foreach (ops[i]) begin
            step(ops[i]);
            e = sb.pop_front();
            a = observed();
            checks++;
            if (a !== e) $display("FAIL swap[%0d] got %h expected %h", i, a, e);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        op_t ops[$];
        snap_t e, a;
        ops = '{mk(0,0,0,0,0,0), mk(1,1,0,0,0,8'hAA), mk(1,1,0,0,0,8'hBB), mk(0,0,0,0,0,0),
                mk(1,1,0,0,0,8'hCC), mk(1,0,1,0,0,0), mk(1,1,1,0,0,8'h9D), mk(1,0,1,0,0,0)};
        foreach (ops[i]) begin
            step(ops[i]);
            e = sb.pop_front();
            a = observed();
            checks++;
            if (a !== e) $display("FAIL back_to_back[%0d] got %h expected %h", i, a, e);
            else passed++;
        end
    endtask

    task automatic test_random();
        op_t o;
        snap_t e, a;
        for (int i = 0; i < 300; i++) begin
            o = mk($urandom_range(0, 40) != 0, $urandom_range(0, 1), $urandom_range(0, 2) == 0,
                   $urandom_range(0, 1), $urandom_range(0, 7) == 0, 8'($urandom));
            step(o);
            e = sb.pop_front();
            a = observed();
            checks++;
            if (a !== e) $display("FAIL random[%0d] got %h expected %h", i, a, e);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_push3();
        test_full();
        test_underflow();
        test_swap();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
